mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one single-port unified memory between the pipelined MIPS instruction-fetch stage (F) and the memory stage (M). Holds the pipeline with its own stall outputs while an access is outstanding, with priority to M. Buffers the fetched word and the load data so that neither is lost while the pipeline is frozen. Sits between the pipeline registers and the memory, alongside the hazard unit; its stalls are OR-ed with the hazard stalls.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- IReqF  in  1  F stage wants the instruction at IAddrF
- IAddrF  in  ADDR_W  PC of the F stage
- InstrF  out  DATA_W  buffered instruction word
- StallIF  out  1  freeze the PC and the F/D register
- DReqM  in  1  M stage access pending (MemtoRegM | MemWriteM)
- DWeM  in  1  1 = store, 0 = load
- DAddrM  in  ADDR_W  ALUOutM
- DWdataM  in  DATA_W  WriteDataM
- DRdataM  out  DATA_W  load data, registered
- StallMem  out  1  freeze all pipeline registers F through W; dominates FlushE
- MemReq  out  1  memory request, registered
- MemWe, MemAddr, MemWdata  out  1/ADDR_W/DATA_W  request fields, registered
- MemRdata  in  DATA_W  valid in the MemAck cycle
- MemAck  in  1  one-cycle completion pulse

## Operation
- States:
  - IDLE: MemReq=0.
  - IFETCH: MemReq=1, MemWe=0.
  - DACCESS: MemReq=1, MemWe=latched DWeM.
- Flags and registers:
  - IBufValid and IBufAddr: address tag of the buffered instruction.
  - DDone: M access completed.
- IHit = IBufValid && (IBufAddr == IAddrF).
- IDLE arbitration, data first:
  - If DReqM && !DDone: go to DACCESS and latch DAddrM/DWeM/DWdataM into Mem*.
  - Else if IReqF && !IHit: go to IFETCH and latch IAddrF.
  - Else stay in IDLE.
- IFETCH on MemAck:
  - InstrF <= MemRdata, IBufAddr <= latched address, IBufValid <= 1.
  - Go to IDLE.
  - The fetch is never aborted, even if DReqM rises meanwhile.
- DACCESS on MemAck:
  - DRdataM <= MemRdata (loads only; stores leave it unchanged).
  - DDone <= 1, go to IDLE.
- StallMem = DReqM && !DDone (combinational).
- StallIF = StallMem | (IReqF && !IHit) (combinational).
- DDone clears on the edge where DDone && !StallMem; M advances at that edge.
- IBufValid clears on the edge where IReqF && IHit && !StallIF, i.e. the instruction was consumed.
- PC redirect (branch/jump): IAddrF changes, so IHit drops and a new fetch is issued. A stale in-flight fetch completes, fills the buffer, then mismatches and is overwritten.
- MemAck outside IFETCH/DACCESS is ignored.

## Timing
- Reset values:
  - state=IDLE.
  - MemReq=0, MemWe=0, MemAddr=0, MemWdata=0.
  - InstrF=0, DRdataM=0.
  - IBufValid=0, IBufAddr=0, DDone=0.
  - StallMem and StallIF follow their inputs.
- Reset mid-access abandons the request; the memory must tolerate a dropped MemReq.
- Mem* fields are stable from MemReq rising until the MemAck cycle inclusive. MemReq falls in the cycle after MemAck.
- Every access returns to IDLE. There is at least one IDLE cycle between consecutive accesses.
- Load with zero-wait memory (DReqM rises in cycle 0, IDLE):
  - cycle 1: DACCESS, MemAck.
  - cycle 2: DDone=1, StallMem=0.
  - Two stall cycles; each memory wait cycle adds one.
- Fetch miss with zero-wait memory: StallIF high for 2 cycles, InstrF valid in cycle 2.
- Simultaneous IReqF miss and DReqM in IDLE: the data access goes first; the fetch follows after one IDLE cycle.
- Inputs from frozen pipeline registers are stable during a stall by construction.

## Structure
- Package mem_arb_pkg:
  - state enum (IDLE, IFETCH, DACCESS), 2 bits.
  - ADDR_W/DATA_W defaults.
- Single flat module, no sub-modules.
- Integration, at top level:
  - StallF = StallF_hz | StallIF | StallMem; StallD likewise.
  - FlushE = FlushE_hz & !StallMem.

## Test plan
- Load, MemAck 1 cycle after MemReq, DAddrM=0x40, MemRdata=0xDEADBEEF → StallMem high 2 cycles; DRdataM=0xDEADBEEF when StallMem drops; DDone clears next cycle.
- Store with memory latency 3, DWdataM=0x1234 → MemWe=1; MemAddr/MemWdata held 3 cycles; StallMem high 4 cycles; DRdataM unchanged.
- IReqF miss at 0x100 and load pending in the same IDLE cycle → DACCESS first; IFETCH at 0x100 only after DDone clears; StallIF covers both.
- Fetch of 0x200 in flight, then IAddrF changes to 0x300 (branch) → 0x200 completes and is buffered; IHit=0; a second fetch at 0x300 is issued; InstrF matches the 0x300 data.
- Fetch completes while StallMem is high → IBufValid held; F consumes the word after StallMem drops, with no refetch of the same address.
- reset_n pulled low during DACCESS → MemReq=0 and state IDLE immediately; after release, the pending DReqM is re-issued from scratch.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and width defaults for the unified-memory port arbiter.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IFETCH  = 2'd1,
      DACCESS = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port unified memory between instruction fetch (F) and the
// memory stage (M), stalling the pipeline while an access is outstanding.
//
// state   | meaning
// IDLE    | no request on the memory port; arbitration point, data first
// IFETCH  | instruction fetch outstanding, MemWe=0
// DACCESS | load/store for the M stage outstanding
import mem_arb_pkg::*;

module mem_port_arbiter #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              IReqF,
   input  logic [ADDR_W-1:0] IAddrF,
   output logic [DATA_W-1:0] InstrF,
   output logic              StallIF,
   input  logic              DReqM,
   input  logic              DWeM,
   input  logic [ADDR_W-1:0] DAddrM,
   input  logic [DATA_W-1:0] DWdataM,
   output logic [DATA_W-1:0] DRdataM,
   output logic              StallMem,
   output logic              MemReq,
   output logic              MemWe,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWdata,
   input  logic [DATA_W-1:0] MemRdata,
   input  logic              MemAck
);

   arb_state_t        state;
   logic              ibuf_valid;
   logic [ADDR_W-1:0] ibuf_addr;
   logic              d_done;
   logic              i_hit;

   assign i_hit    = ibuf_valid && (ibuf_addr == IAddrF);
   assign StallMem = DReqM && !d_done;
   assign StallIF  = StallMem || (IReqF && !i_hit);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         MemReq     <= 1'b0;
         MemWe      <= 1'b0;
         MemAddr    <= '0;
         MemWdata   <= '0;
         InstrF     <= '0;
         DRdataM    <= '0;
         ibuf_valid <= 1'b0;
         ibuf_addr  <= '0;
         d_done     <= 1'b0;
      end else begin
         // d_done lives for exactly the cycle in which M advances past the access.
         if (d_done && !StallMem)
            d_done <= 1'b0;
         if (IReqF && i_hit && !StallIF)
            ibuf_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (DReqM && !d_done) begin
                  state    <= DACCESS;
                  MemReq   <= 1'b1;
                  MemWe    <= DWeM;
                  MemAddr  <= DAddrM;
                  MemWdata <= DWdataM;
               end else if (IReqF && !i_hit) begin
                  state   <= IFETCH;
                  MemReq  <= 1'b1;
                  MemWe   <= 1'b0;
                  MemAddr <= IAddrF;
               end
            end
            IFETCH: begin
               // Never aborted; a stale fill is simply overwritten by the next miss.
               if (MemAck) begin
                  InstrF     <= MemRdata;
                  ibuf_addr  <= MemAddr;
                  ibuf_valid <= 1'b1;
                  MemReq     <= 1'b0;
                  state      <= IDLE;
               end
            end
            DACCESS: begin
               if (MemAck) begin
                  if (!MemWe)
                     DRdataM <= MemRdata;
                  d_done <= 1'b1;
                  MemReq <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               MemReq <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule
